// File: rtl/reg_select_scoreboard.sv
// Register-select / enable-encode unit with a write-pending scoreboard.
// Latches Ra/Rb/Rc from the IR, drives one-hot bus enables and raises stall on RAW hazards.
module reg_select_scoreboard #(
   parameter  int NUM_REGS = 16,
   parameter  int IR_W     = 32,
   parameter  int RA_LSB   = 23,
   parameter  int RB_LSB   = 19,
   parameter  int RC_LSB   = 15,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clock,
   input  logic                clear_n,
   input  logic [IR_W-1:0]     ir_in,
   input  logic                ir_load,
   input  logic                gra,
   input  logic                grb,
   input  logic                grc,
   input  logic                rin,
   input  logic                rout,
   input  logic                baout,
   input  logic                issue,
   input  logic                use_rb,
   input  logic                use_rc,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_addr,
   output logic [NUM_REGS-1:0] reg_in,
   output logic [NUM_REGS-1:0] reg_out,
   output logic                ba_zero,
   output logic [ADDR_W-1:0]   sel_addr,
   output logic                stall,
   output logic [NUM_REGS-1:0] pending,
   output logic                sel_err
);

   logic [ADDR_W-1:0]   ra_q, rb_q, rc_q;
   logic [ADDR_W-1:0]   sel_raw;
   logic [NUM_REGS-1:0] sel_oh;
   logic [NUM_REGS-1:0] pending_nxt;
   logic                any_gr, multi_gr, stall_raw;
   logic                unused_ir;

   // Only the three field slices of the IR are consumed.
   assign unused_ir = ^ir_in;

   assign any_gr   = gra | grb | grc;
   assign multi_gr = (gra & grb) | (gra & grc) | (grb & grc);

   always_comb begin
      sel_raw = '0;
      if (gra)      sel_raw = ra_q;
      else if (grb) sel_raw = rb_q;
      else if (grc) sel_raw = rc_q;
   end

   assign sel_oh   = {{(NUM_REGS-1){1'b0}}, 1'b1} << sel_raw;
   assign sel_addr = clear_n ? sel_raw : '0;

   // BAout of R0 means constant zero on the bus, so R0 must not drive it.
   always_comb begin
      reg_in  = '0;
      reg_out = '0;
      ba_zero = 1'b0;
      if (clear_n && any_gr) begin
         if (rin) reg_in = sel_oh;
         if (baout && (sel_raw == '0)) ba_zero = 1'b1;
         else if (rout || baout)       reg_out = sel_oh;
      end
   end

   assign stall_raw = (use_rb & pending[rb_q]) | (use_rc & pending[rc_q]);
   assign stall     = clear_n & stall_raw;

   // Clear first so a same-cycle set to the same register wins.
   always_comb begin
      pending_nxt = pending;
      if (wb_valid)          pending_nxt[wb_addr] = 1'b0;
      if (issue && !stall)   pending_nxt[ra_q]    = 1'b1;
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
         pending <= '0;
         sel_err <= 1'b0;
      end else begin
         if (ir_load) begin
            ra_q <= ir_in[RA_LSB +: ADDR_W];
            rb_q <= ir_in[RB_LSB +: ADDR_W];
            rc_q <= ir_in[RC_LSB +: ADDR_W];
         end
         if (multi_gr && (rin || rout || baout)) sel_err <= 1'b1;
         pending <= pending_nxt;
      end
   end

endmodule

// File: tb/tb_reg_select_scoreboard.sv
// Self-checking bench for reg_select_scoreboard: directed literal checks plus
// randomized traffic compared each cycle against a behavioural register-file model.
module tb_reg_select_scoreboard;

   logic        clock = 1'b0;
   logic        clear_n;
   logic [31:0] ir_in;
   logic        ir_load, gra, grb, grc, rin, rout, baout, issue, use_rb, use_rc, wb_valid;
   logic [3:0]  wb_addr;
   logic [15:0] reg_in, reg_out, pending;
   logic        ba_zero, stall, sel_err;
   logic [3:0]  sel_addr;

   logic [31:0] b_ir_in;
   logic        b_ir_load, b_gra, b_grb, b_grc, b_rin, b_rout, b_baout, b_issue;
   logic        b_use_rb, b_use_rc, b_wb_valid;
   logic [4:0]  b_wb_addr, b_sel_addr;
   logic [31:0] b_reg_in, b_reg_out, b_pending;
   logic        b_ba_zero, b_stall, b_sel_err;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 0;

   always #5 clock = ~clock;

   reg_select_scoreboard dut (
      .clock(clock), .clear_n(clear_n), .ir_in(ir_in), .ir_load(ir_load),
      .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
      .issue(issue), .use_rb(use_rb), .use_rc(use_rc), .wb_valid(wb_valid),
      .wb_addr(wb_addr), .reg_in(reg_in), .reg_out(reg_out), .ba_zero(ba_zero),
      .sel_addr(sel_addr), .stall(stall), .pending(pending), .sel_err(sel_err)
   );

   reg_select_scoreboard #(.NUM_REGS(32), .RA_LSB(22), .RB_LSB(17), .RC_LSB(12)) dut32 (
      .clock(clock), .clear_n(clear_n), .ir_in(b_ir_in), .ir_load(b_ir_load),
      .gra(b_gra), .grb(b_grb), .grc(b_grc), .rin(b_rin), .rout(b_rout), .baout(b_baout),
      .issue(b_issue), .use_rb(b_use_rb), .use_rc(b_use_rc), .wb_valid(b_wb_valid),
      .wb_addr(b_wb_addr), .reg_in(b_reg_in), .reg_out(b_reg_out), .ba_zero(b_ba_zero),
      .sel_addr(b_sel_addr), .stall(b_stall), .pending(b_pending), .sel_err(b_sel_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: register-number fields, one pending flag per register, sticky error.
   int m_ra = 0, m_rb = 0, m_rc = 0;
   bit m_pend [16];
   bit m_err = 0;

   function automatic bit model_stall();
      return (use_rb && m_pend[m_rb]) || (use_rc && m_pend[m_rc]);
   endfunction

   always @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         m_ra = 0; m_rb = 0; m_rc = 0; m_err = 0;
         foreach (m_pend[k]) m_pend[k] = 0;
      end else begin
         bit st;
         st = model_stall();
         if ((int'(gra) + int'(grb) + int'(grc)) >= 2 && (rin || rout || baout)) m_err = 1;
         if (wb_valid) m_pend[wb_addr] = 0;
         if (issue && !st) m_pend[m_ra] = 1;
         if (ir_load) begin
            m_ra = int'((ir_in >> 23) & 32'hF);
            m_rb = int'((ir_in >> 19) & 32'hF);
            m_rc = int'((ir_in >> 15) & 32'hF);
         end
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         int          sel;
         bit          any;
         logic [15:0] e_in, e_out, e_pend;
         bit          e_ba, e_stall;
         any   = gra || grb || grc;
         sel   = gra ? m_ra : (grb ? m_rb : (grc ? m_rc : 0));
         e_in  = 16'h0; e_out = 16'h0; e_ba = 0;
         if (any && rin) e_in = 16'(1 << sel);
         if (any && baout && sel == 0)   e_ba = 1;
         else if (any && (rout || baout)) e_out = 16'(1 << sel);
         e_stall = model_stall();
         for (int k = 0; k < 16; k++) e_pend[k] = m_pend[k];
         if (!clear_n) begin
            e_in = 0; e_out = 0; e_ba = 0; e_stall = 0; sel = 0;
         end
         check("cmp_reg_in",   64'(reg_in),   64'(e_in));
         check("cmp_reg_out",  64'(reg_out),  64'(e_out));
         check("cmp_ba_zero",  64'(ba_zero),  64'(e_ba));
         check("cmp_sel_addr", 64'(sel_addr), 64'(sel));
         check("cmp_stall",    64'(stall),    64'(e_stall));
         check("cmp_pending",  64'(pending),  64'(e_pend));
         check("cmp_sel_err",  64'(sel_err),  64'(m_err));
      end
   end

   task automatic idle();
      ir_load = 0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
      issue = 0; use_rb = 0; use_rc = 0; wb_valid = 0; wb_addr = 0;
      b_ir_load = 0; b_gra = 0; b_grb = 0; b_grc = 0; b_rin = 0; b_rout = 0; b_baout = 0;
      b_issue = 0; b_use_rb = 0; b_use_rc = 0; b_wb_valid = 0; b_wb_addr = 0;
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
      idle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      clear_n = 0; ir_in = 0; b_ir_in = 0;
      idle();
      cmp_en = 1;
      repeat (2) @(posedge clock);
      #1; gra = 1; rin = 1; rout = 1;
      @(negedge clock);
      check("rst_reg_in",  64'(reg_in),  64'h0);
      check("rst_reg_out", 64'(reg_out), 64'h0);
      check("rst_pending", 64'(pending), 64'h0);
      check("rst_sel_err", 64'(sel_err), 64'h0);
      nxt(); clear_n = 1; ir_in = 32'h029C8000; ir_load = 1;
      nxt(); gra = 1; rin = 1;
      @(negedge clock); check("ra_rin", 64'(reg_in), 64'h0020);
      nxt(); grb = 1; rout = 1;
      @(negedge clock); check("rb_rout", 64'(reg_out), 64'h0008);
      nxt(); grc = 1; rout = 1;
      @(negedge clock); check("rc_rout", 64'(reg_out), 64'h0200);
      nxt(); rin = 1;
      @(negedge clock); check("no_gr_rin", 64'(reg_in), 64'h0);
      nxt(); ir_in = 32'h02800000; ir_load = 1;
      nxt(); grb = 1; baout = 1;
      @(negedge clock);
      check("r0_baout_out", 64'(reg_out), 64'h0);
      check("r0_baout_bz",  64'(ba_zero), 64'h1);
      nxt(); grb = 1; rout = 1;
      @(negedge clock);
      check("r0_rout_out", 64'(reg_out), 64'h0001);
      check("r0_rout_bz",  64'(ba_zero), 64'h0);
      nxt(); issue = 1;
      nxt(); ir_in = 32'h00280000; ir_load = 1;
      @(negedge clock); check("issue_pend", 64'(pending), 64'h0020);
      nxt(); use_rb = 1; issue = 1;
      @(negedge clock); check("raw_stall", 64'(stall), 64'h1);
      nxt(); use_rb = 1; wb_valid = 1; wb_addr = 5;
      @(negedge clock);
      check("stalled_issue", 64'(pending), 64'h0020);
      check("wb_cycle_stall", 64'(stall), 64'h1);
      nxt(); use_rb = 1;
      @(negedge clock);
      check("wb_release", 64'(stall), 64'h0);
      check("wb_cleared", 64'(pending), 64'h0);
      nxt(); ir_in = 32'h029C8000; ir_load = 1;
      nxt(); issue = 1; wb_valid = 1; wb_addr = 5;
      nxt(); gra = 1; grb = 1; rin = 1;
      @(negedge clock);
      check("set_wins", 64'(pending), 64'h0020);
      check("multi_prio", 64'(reg_in), 64'h0020);
      nxt();
      @(negedge clock); check("sel_err_set", 64'(sel_err), 64'h1);
      repeat (3) nxt();
      @(negedge clock); check("sel_err_sticky", 64'(sel_err), 64'h1);
      nxt(); gra = 1; rin = 1;
      #2; clear_n = 0;
      #1;
      check("async_pend",  64'(pending), 64'h0);
      check("async_regin", 64'(reg_in),  64'h0);
      check("async_err",   64'(sel_err), 64'h0);
      @(posedge clock); #1; clear_n = 1;
      @(negedge clock);
      check("post_rst_sel", 64'(sel_addr), 64'h0);
      check("post_rst_in",  64'(reg_in),   64'h0001);
      nxt(); b_ir_in = 32'h07C00000; b_ir_load = 1;
      nxt(); b_gra = 1; b_rout = 1; b_issue = 1;
      @(negedge clock); check("n32_rout", 64'(b_reg_out), 64'h80000000);
      nxt(); b_wb_valid = 1; b_wb_addr = 5'd31;
      @(negedge clock); check("n32_pend_set", 64'(b_pending), 64'h80000000);
      nxt();
      @(negedge clock); check("n32_pend_clr", 64'(b_pending), 64'h0);

      for (int i = 0; i < 800; i++) begin
         nxt();
         if (!clear_n) clear_n = 1;
         else if ($urandom_range(0, 99) < 2) clear_n = 0;
         ir_in    = $urandom;
         ir_load  = ($urandom_range(0, 3) == 0);
         gra      = ($urandom_range(0, 2) == 0);
         grb      = ($urandom_range(0, 2) == 0);
         grc      = ($urandom_range(0, 2) == 0);
         rin      = $urandom_range(0, 1) == 1;
         rout     = $urandom_range(0, 1) == 1;
         baout    = ($urandom_range(0, 3) == 0);
         issue    = ($urandom_range(0, 2) == 0);
         use_rb   = $urandom_range(0, 1) == 1;
         use_rc   = $urandom_range(0, 1) == 1;
         wb_valid = ($urandom_range(0, 2) == 0);
         wb_addr  = 4'($urandom_range(0, 15));
      end
      nxt(); clear_n = 1;
      @(negedge clock);
      cmp_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
